// File: rtl/mms_pkg.sv
// Shared types and constants for the min/max frame sequencer.
// The state encoding, mode constants and default data width live here so every file agrees on them.
package mms_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/mms_cmp2.sv
// Strict unsigned compare deciding whether a new number b replaces the accumulator a.
// Ties never pick b, so the earlier value is kept.
module mms_cmp2
  import mms_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             select,
  output logic             pick_b
);

  assign pick_b = (select == MODE_MIN) ? (b < a) : (b > a);

endmodule

// File: rtl/mms_seq_ctrl.sv
// Frame sequencer: accepts len+1 numbers after a start request and reports their max or min.
// All outputs are registered; the result is held until the consumer handshakes it away.
//
//   state   | meaning
//   IDLE    | waiting for start; mode and length are captured on start
//   RUN     | in_ready high, numbers folded into the accumulator on each transfer
//   DONE    | result valid, held until out_ready
module mms_seq_ctrl
  import mms_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             select,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_mode;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W:0]   r_count;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_xfer;
  logic             w_first;
  logic             w_pick;
  logic [WIDTH-1:0] w_next_acc;

  // r_in_ready is only ever high in RUN, so it doubles as the state qualifier
  assign w_xfer     = r_in_ready & in_valid;
  assign w_first    = (r_count == ({1'b0, r_len} + CNT_ONE));
  assign w_next_acc = (w_first || w_pick) ? number : r_acc;

  mms_cmp2 #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a     (r_acc),
    .b     (number),
    .select(r_mode),
    .pick_b(w_pick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_MAX;
      r_len       <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode     <= select;
            r_len      <= len;
            r_count    <= {1'b0, len} + CNT_ONE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            r_acc   <= w_next_acc;
            r_count <= r_count - CNT_ONE;
            if (r_count == CNT_ONE) begin
              r_result    <= w_next_acc;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mms_seq_ctrl.sv
// Self-checking bench for mms_seq_ctrl: directed vector table, backpressure/reset sequences,
// and random frames compared against a max/min reference computed over the frame's numbers.
module tb_mms_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       select;
  logic [2:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] number;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  mms_seq_ctrl #(.WIDTH(8), .LEN_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .select   (select),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .number   (number),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       sel;
    int         ln;
    logic [7:0] nums [8];
    int         gap;
    int         bp;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: the largest (sel=0) or smallest (sel=1) of the first ln+1 numbers.
  function automatic logic [7:0] ref_result(input logic sel, input int ln, input logic [7:0] nums [8]);
    int best;
    best = sel ? 256 : -1;
    for (int i = 0; i <= ln; i++) begin
      if (!sel && int'(nums[i]) > best) best = int'(nums[i]);
      if (sel && int'(nums[i]) < best) best = int'(nums[i]);
    end
    return best[7:0];
  endfunction

  // Runs a full frame from IDLE: start, ln+1 transfers with gaps, bp cycles of backpressure
  // (start pulsed throughout), then a handshake with start also high in that cycle.
  task automatic run_frame(input string tag, input logic sel, input int ln, input logic [7:0] nums [8],
                           input int gap, input int bp, input logic [7:0] exp);
    start = 1'b1; select = sel; len = ln[2:0];
    @(negedge clk);
    start = 1'b0; select = ~sel; len = 3'($urandom);
    chk({tag, " busy_in_run"}, 32'(busy), 32'd1);
    for (int i = 0; i <= ln; i++) begin
      int t = 0;
      while (!in_ready && t < 8) begin
        @(negedge clk);
        t++;
      end
      chk({tag, " in_ready_before_xfer"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; number = nums[i];
      @(negedge clk);
      in_valid = 1'b0; number = 8'($urandom);
      if (i < ln) begin
        chk({tag, " no_early_out_valid"}, 32'(out_valid), 32'd0);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk({tag, " gap_no_done"}, 32'({in_ready, out_valid}), 32'b10);
        end
      end
    end
    chk({tag, " out_valid_after_last"}, 32'(out_valid), 32'd1);
    chk({tag, " in_ready_low_done"}, 32'(in_ready), 32'd0);
    chk({tag, " result"}, 32'(result), 32'(exp));
    for (int b = 0; b < bp; b++) begin
      start = 1'b1; in_valid = 1'b1; number = 8'($urandom); select = ~sel; len = 3'($urandom);
      @(negedge clk);
      chk({tag, " bp_hold"}, 32'({out_valid, busy, in_ready, result}), 32'({1'b1, 1'b1, 1'b0, exp}));
    end
    in_valid = 1'b0; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    chk({tag, " idle_after_hs"}, 32'({out_valid, busy, in_ready}), 32'b000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rn [8];
    logic       rsel;
    int         rln;

    vecs[0] = '{"max8",    1'b0, 7, '{8'd3, 8'd200, 8'd17, 8'd200, 8'd0, 8'd255, 8'd9, 8'd1}, 0, 0, 8'd255};
    vecs[1] = '{"min_gap", 1'b1, 3, '{8'd40, 8'd5, 8'd5, 8'd90, 8'd0, 8'd0, 8'd0, 8'd0},     2, 1, 8'd5};
    vecs[2] = '{"single",  1'b1, 0, '{8'hA5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},     0, 0, 8'hA5};
    vecs[3] = '{"max_all0",1'b0, 7, '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},       0, 0, 8'd0};
    vecs[4] = '{"min_ff",  1'b1, 7, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1, 0, 8'hFF};
    vecs[5] = '{"min_last",1'b1, 7, '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2},       0, 0, 8'd2};
    vecs[6] = '{"backpr",  1'b0, 2, '{8'd254, 8'd255, 8'd128, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 4, 8'd255};

    rst_n = 1'b0; start = 1'b0; select = 1'b0; len = '0;
    in_valid = 1'b0; number = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({in_ready, out_valid, busy, result}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; number = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle_ignores_in_valid", 32'({in_ready, out_valid, busy}), 32'd0);

    for (int v = 0; v < 7; v++)
      run_frame(vecs[v].name, vecs[v].sel, vecs[v].ln, vecs[v].nums, vecs[v].gap, vecs[v].bp, vecs[v].exp);

    // Reset three numbers into an eight-number frame, with start/in_valid/out_ready also high.
    start = 1'b1; select = 1'b0; len = 3'd7;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; number = 8'(10 + i);
      @(negedge clk);
    end
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("midframe_reset", 32'({in_ready, out_valid, busy, result}), 32'd0);
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_out_valid", 32'({out_valid, busy}), 32'd0);
    end
    rn = '{8'd7, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_frame("after_reset", 1'b0, 1, rn, 0, 0, 8'd8);

    for (int k = 0; k < 40; k++) begin
      rsel = 1'($urandom);
      rln  = $urandom_range(0, 7);
      for (int i = 0; i < 8; i++)
        rn[i] = (k % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      run_frame("rand", rsel, rln, rn, $urandom_range(0, 2), $urandom_range(0, 3),
                ref_result(rsel, rln, rn));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
